// File: rtl/regfile_wb_arbiter.sv
// Two-requester round-robin writeback arbiter for the register file, with a
// per-register scoreboard of outstanding writes.
module regfile_wb_arbiter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0_valid,
    input  logic [4:0]      req0_rd,
    input  logic [XLEN-1:0] req0_data,
    output logic            req0_ready,
    input  logic            req1_valid,
    input  logic [4:0]      req1_rd,
    input  logic [XLEN-1:0] req1_data,
    output logic            req1_ready,
    input  logic            issue_valid,
    input  logic [4:0]      issue_rd,
    output logic            wb_reg_write,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic [31:0]     pending
);

    typedef enum logic {
        LAST_REQ0 = 1'b0,
        LAST_REQ1 = 1'b1
    } grant_t;

    grant_t          last_grant;
    logic            grant0;
    logic            grant1;
    logic            xfer;
    logic [4:0]      sel_rd;
    logic [XLEN-1:0] sel_data;
    logic [31:0]     set_mask;
    logic [31:0]     clr_mask;

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!rst) begin
            if (req0_valid && req1_valid) begin
                grant0 = (last_grant == LAST_REQ1);
                grant1 = (last_grant == LAST_REQ0);
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
        xfer     = grant0 | grant1;
        sel_rd   = grant1 ? req1_rd : req0_rd;
        sel_data = grant1 ? req1_data : req0_data;

        // Set is OR-ed in after the clear so a same-index issue keeps the bit.
        set_mask = '0;
        clr_mask = '0;
        if (issue_valid) set_mask[issue_rd] = 1'b1;
        if (xfer)        clr_mask[sel_rd]   = 1'b1;
        set_mask[0] = 1'b0;
        clr_mask[0] = 1'b0;
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant   <= LAST_REQ1;
            wb_reg_write <= 1'b0;
            wb_rd        <= '0;
            wb_data      <= '0;
            pending      <= '0;
        end else begin
            wb_reg_write <= xfer && (sel_rd != 5'd0);
            if (xfer && (sel_rd != 5'd0)) begin
                wb_rd   <= sel_rd;
                wb_data <= sel_data;
            end
            if (xfer) last_grant <= grant1 ? LAST_REQ1 : LAST_REQ0;
            pending <= (pending & ~clr_mask) | set_mask;
        end
    end

endmodule
